demux_dispatch_1x4: RTL and testbench



---
 rtl/demux_dispatch_1x4.sv | 99 +++++++++
 tb/tb_demux_dispatch_1x4.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_1x4.sv
// Sequencing controller for a 1x4 demultiplexer: accepts beats on one valid/ready
// input, picks a channel (round-robin or explicit), and holds each beat until it is taken.
module demux_dispatch_1x4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_dest,
  input  logic               mode,
  input  logic [3:0]         ch_en,
  output logic [3:0]         y_valid,
  input  logic [3:0]         y_ready,
  output logic [4*WIDTH-1:0] y_data,
  output logic [1:0]         sel,
  output logic [15:0]        deliver_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_eff, rr_pick, target;
  logic [WIDTH-1:0] data_q;
  logic             mode_q;
  logic             deliver, can_accept, accept;

  assign deliver = (state == HOLD) && y_ready[sel];

  // A same-cycle accept must see the pointer as it will be after this delivery,
  // otherwise back-to-back round-robin beats would land on the same channel.
  assign ptr_eff = (deliver && !mode_q) ? sel + 2'd1 : ptr;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    logic [1:0] idx;
    rr_pick = ptr_eff;
    idx     = ptr_eff;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_eff + 2'(i);
      if (ch_en[idx]) rr_pick = idx;
    end
  end

  assign target     = mode ? in_dest : rr_pick;
  assign can_accept = mode ? ch_en[in_dest] : (ch_en != 4'b0000);
  assign in_ready   = rst_n && can_accept && ((state == IDLE) || deliver);
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HOLD;
      HOLD:    if (accept) state_nxt = HOLD;
               else if (deliver) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      sel         <= 2'd0;
      mode_q      <= 1'b0;
      ptr         <= 2'd0;
      deliver_cnt <= 16'd0;
    end else begin
      if (accept) begin
        data_q <= in_data;
        sel    <= target;
        mode_q <= mode;
      end
      if (deliver) begin
        deliver_cnt <= deliver_cnt + 16'd1;
        if (!mode_q) ptr <= sel + 2'd1;
      end
    end
  end

  // Outputs decode only registered state, so they never glitch on input changes.
  always_comb begin
    y_valid = 4'b0000;
    y_data  = '0;
    if (state == HOLD) begin
      y_valid[sel]              = 1'b1;
      y_data[sel*WIDTH +: WIDTH] = data_q;
    end
  end

endmodule

// File: tb/tb_demux_dispatch_1x4.sv
// Self-checking bench for demux_dispatch_1x4: directed stimulus with a scoreboard
// queue of expected (channel, data) pairs drained by an independent monitor.
module tb_demux_dispatch_1x4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, mode;
  logic [7:0]  in_data;
  logic [1:0]  in_dest, sel;
  logic [3:0]  ch_en, y_valid, y_ready;
  logic [31:0] y_data;
  logic [15:0] deliver_cnt;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   sb_off = 1'b0;

  demux_dispatch_1x4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .mode(mode), .ch_en(ch_en),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .sel(sel),
    .deliver_cnt(deliver_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat is delivered at the edge following a negedge where valid & ready.
  always @(negedge clk) begin
    if (rst_n && !sb_off && ((y_valid & y_ready) != 4'b0000)) begin
      if (sb.size() == 0) begin
        check("spurious_beat", {28'd0, y_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dlv_valid", {28'd0, y_valid}, 32'd1 << e.ch);
        check("dlv_data", y_data, {24'd0, e.data} << (8 * e.ch));
        check("dlv_sel", {30'd0, sel}, {30'd0, e.ch});
      end
    end
  end

  // Present one beat and wait for acceptance; returns 1 time unit after the accept edge.
  task automatic send(input logic [7:0] d, input logic m, input logic [1:0] dst,
                      input logic [1:0] exp_ch);
    bit done;
    done     = 1'b0;
    in_data  = d;
    mode     = m;
    in_dest  = dst;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{exp_ch, d});
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [15:0] exp_cnt);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (y_valid != 4'b0000 && c < 20);
    check("drain_idle", {28'd0, y_valid}, 32'd0);
    check("deliver_cnt", {16'd0, deliver_cnt}, {16'd0, exp_cnt});
    check("sb_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    logic [1:0] exp_rr [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] exp_alt[4] = '{2'd1, 2'd3, 2'd1, 2'd3};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dest = 2'd0;
    mode = 1'b0; ch_en = 4'b1111; y_ready = 4'b1111;
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_y_valid", {28'd0, y_valid}, 32'd0);
    check("rst_y_data", y_data, 32'd0);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_cnt", {16'd0, deliver_cnt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin over all four channels, one beat per cycle.
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, 2'd0, exp_rr[i]);
    check("throughput_cycles", cyc - c0, 32'd8);
    drain(16'd8);

    // Round-robin with channels 0 and 2 disabled.
    ch_en = 4'b1010;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b0, 2'd0, exp_alt[i]);
    drain(16'd12);
    ch_en = 4'b1111;

    // Explicit destination with backpressure on channel 2.
    y_ready = 4'b1011;
    send(8'hA5, 1'b1, 2'd2, 2'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_y_valid", {28'd0, y_valid}, 32'h4);
      check("bp_y_data", y_data, 32'h00A5_0000);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    y_ready = 4'b1111;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drain(16'd13);

    // Explicit destination to a disabled channel stalls until enabled.
    ch_en = 4'b1101; mode = 1'b1; in_dest = 2'd1; in_data = 8'h3C; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_y_valid", {28'd0, y_valid}, 32'd0);
      @(posedge clk); #1;
    end
    ch_en = 4'b1111;
    send(8'h3C, 1'b1, 2'd1, 2'd1);
    drain(16'd14);

    // Held beat ignores later ch_en/mode changes.
    y_ready = 4'b1110;
    send(8'h77, 1'b1, 2'd0, 2'd0);
    ch_en = 4'b1110; mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hold_y_valid", {28'd0, y_valid}, 32'h1);
      check("hold_sel", {30'd0, sel}, 32'd0);
      @(posedge clk); #1;
    end
    y_ready = 4'b1111;
    drain(16'd15);
    ch_en = 4'b1111;

    // Bulk deliveries up to 0xFFFE, then step across the wrap.
    sb_off = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    repeat (65519) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("cnt_fffe", {16'd0, deliver_cnt}, 32'h0000_FFFE);
    sb_off = 1'b0;
    send(8'hC1, 1'b1, 2'd3, 2'd3); drain(16'hFFFF);
    send(8'hC2, 1'b1, 2'd3, 2'd3); drain(16'h0000);
    send(8'hC3, 1'b1, 2'd3, 2'd3); drain(16'h0001);

    // Reset while holding a beat: it is discarded and never appears.
    y_ready = 4'b0000;
    send(8'h5A, 1'b1, 2'd2, 2'd2);
    @(negedge clk);
    check("prerst_y_valid", {28'd0, y_valid}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_y_valid", {28'd0, y_valid}, 32'd0);
    check("midrst_y_data", y_data, 32'd0);
    check("midrst_cnt", {16'd0, deliver_cnt}, 32'd0);
    check("midrst_sel", {30'd0, sel}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1; y_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_y_valid", {28'd0, y_valid}, 32'd0);
    end
    check("postrst_cnt", {16'd0, deliver_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
